// File: rtl/key_seq_pkg.sv
// Shared constants, state encoding and helpers for the key sequencer.
package key_seq_pkg;

  localparam int unsigned KEY_W  = 4;
  localparam int unsigned CODE_W = 8;
  localparam int unsigned STEP_W = 2;

  localparam int unsigned DEF_CODE_LEN    = 4;
  localparam int unsigned DEF_HOLD_CYCLES = 2;
  localparam int unsigned DEF_GAP_CYCLES  = 1;
  localparam int unsigned DEF_TIMEOUT     = 8;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_PRESS   = 3'd1;
  localparam logic [2:0] ST_RELEASE = 3'd2;
  localparam logic [2:0] ST_WAIT    = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  typedef enum logic [2:0] {
    IDLE        = ST_IDLE,
    PRESS       = ST_PRESS,
    RELEASE     = ST_RELEASE,
    WAIT_UNLOCK = ST_WAIT,
    DONE        = ST_DONE
  } state_e;

  // Largest of three phase lengths, used to size the shared counter.
  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // One-hot key for a given step of a packed 2-bit-per-step code.
  function automatic logic [KEY_W-1:0] key_onehot(input logic [CODE_W-1:0] code,
                                                  input logic [STEP_W-1:0] step);
    logic [1:0] idx;
    idx = code[{step, 1'b0} +: 2];
    return KEY_W'(1) << idx;
  endfunction

endpackage

// File: rtl/key_seq_timer.sv
// Reloadable down-counter; expired_o is high while the count sits at zero.
module key_seq_timer #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] value_i,
  output logic         expired_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         expired_q;

  // Next count: reload wins, otherwise count down and stick at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = value_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Count register with expiry flag registered alongside it.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      expired_q <= 1'b1;
    end else begin
      cnt_q     <= cnt_d;
      expired_q <= (cnt_d == '0);
    end
  end

  assign expired_o = expired_q;

endmodule

// File: rtl/key_sequencer.sv
// Drives a code into a keypad lock one key at a time, then waits for unlock.
// Optional macro KEY_SEQUENCER_PROGRESS_CHECK_EN: abort early when the lock's
// progress bit for the current step is low at the end of its release gap.
module key_sequencer
  import key_seq_pkg::*;
#(
  parameter int unsigned CODE_LEN    = DEF_CODE_LEN,
  parameter int unsigned HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int unsigned GAP_CYCLES  = DEF_GAP_CYCLES,
  parameter int unsigned TIMEOUT     = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CODE_W-1:0] code,
  output logic [KEY_W-1:0]  keys,
  input  logic              unlock,
  input  logic [KEY_W-1:0]  progress,
  output logic              busy,
  output logic              done,
  output logic              success
);

  localparam int unsigned CNT_MAX = max3(HOLD_CYCLES, GAP_CYCLES, TIMEOUT);
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  state_e              state_q, state_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic                success_q, success_d;
  logic [KEY_W-1:0]    keys_q;
  logic                busy_q, done_q;
  logic                tmr_load;
  logic [CNT_W-1:0]    tmr_value;
  logic                tmr_expired;

`ifndef KEY_SEQUENCER_PROGRESS_CHECK_EN
  logic progress_unused;
  assign progress_unused = ^progress;
`endif

  key_seq_timer #(.W(CNT_W)) u_timer (
    .clk       (clk),
    .reset     (reset),
    .load_i    (tmr_load),
    .value_i   (tmr_value),
    .expired_o (tmr_expired)
  );

  // Next-state, latched code/step/result, and counter reload on state entry.
  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    step_d    = step_q;
    success_d = success_q;
    tmr_load  = 1'b0;
    tmr_value = '0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = PRESS;
          code_d    = code;
          step_d    = '0;
          success_d = 1'b0;
        end
      end
      PRESS: begin
        if (tmr_expired) begin
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (tmr_expired) begin
`ifdef KEY_SEQUENCER_PROGRESS_CHECK_EN
          if (!progress[step_q]) begin
            state_d   = DONE;
            success_d = 1'b0;
          end else
`endif
          if (32'(step_q) < CODE_LEN - 1) begin
            state_d = PRESS;
            step_d  = step_q + STEP_W'(1);
          end else begin
            state_d = WAIT_UNLOCK;
          end
        end
      end
      WAIT_UNLOCK: begin
        if (unlock) begin
          state_d   = DONE;
          success_d = 1'b1;
        end else if (tmr_expired) begin
          state_d   = DONE;
          success_d = 1'b0;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    tmr_load = (state_d != state_q);
    case (state_d)
      PRESS:       tmr_value = CNT_W'(HOLD_CYCLES - 1);
      RELEASE:     tmr_value = CNT_W'(GAP_CYCLES - 1);
      WAIT_UNLOCK: tmr_value = CNT_W'(TIMEOUT - 1);
      default:     tmr_value = '0;
    endcase
  end

  // State and registered outputs, computed from the next state so they align.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      code_q    <= '0;
      step_q    <= '0;
      success_q <= 1'b0;
      keys_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      code_q    <= code_d;
      step_q    <= step_d;
      success_q <= success_d;
      keys_q    <= (state_d == PRESS) ? key_onehot(code_d, step_d) : '0;
      busy_q    <= (state_d != IDLE);
      done_q    <= (state_d == DONE);
    end
  end

  assign keys    = keys_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign success = success_q;

endmodule

// File: tb/tb_key_sequencer.sv
// Self-checking bench for key_sequencer: directed scenarios plus random codes
// compared cycle by cycle against a timeline model of the key sequence.
module tb_key_sequencer;

  localparam int unsigned CL = 4;
  localparam int unsigned H  = 2;
  localparam int unsigned G  = 1;
  localparam int unsigned T  = 8;
  localparam int          L  = int'(CL * (H + G)) + 1;

  logic       clk = 1'b0;
  logic       reset, start, unlock;
  logic [7:0] code;
  logic [3:0] progress, keys;
  logic       busy, done, success;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  key_sequencer #(
    .CODE_LEN(CL), .HOLD_CYCLES(H), .GAP_CYCLES(G), .TIMEOUT(T)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .code(code), .keys(keys),
    .unlock(unlock), .progress(progress), .busy(busy), .done(done),
    .success(success)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag, input logic exp_s);
    chk({tag, ".keys"}, keys, 4'b0000);
    chk({tag, ".busy"}, {3'b0, busy}, 4'b0000);
    chk({tag, ".done"}, {3'b0, done}, 4'b0000);
    chk({tag, ".success"}, {3'b0, success}, {3'b0, exp_s});
  endtask

  // Reference: cycle index of done and the result, from the timeline rules.
  // u is the first cycle after start at which unlock is held high.
  function automatic void model(input logic [3:0] p, input int u,
                                output int d, output logic s);
`ifdef KEY_SEQUENCER_PROGRESS_CHECK_EN
    for (int k = 0; k < int'(CL); k++) begin
      if (!p[k]) begin
        d = (k + 1) * int'(H + G) + 1;
        s = 1'b0;
        return;
      end
    end
`else
    if (p == 4'hx) d = 0;
`endif
    if (u <= L + int'(T) - 1) begin
      d = ((u > L) ? u : L) + 1;
      s = 1'b1;
    end else begin
      d = L + int'(T);
      s = 1'b0;
    end
  endfunction

  function automatic logic [3:0] exp_keys(input logic [7:0] c, input int n);
    int pos, stp, off;
    logic [1:0] idx;
    logic [3:0] one;
    pos = n - 1;
    stp = pos / int'(H + G);
    off = pos % int'(H + G);
    one = 4'b0001;
    if (n < L && off < int'(H)) begin
      idx = c[2*stp +: 2];
      return one << idx;
    end
    return 4'b0000;
  endfunction

  // noise: 0 none, 1 start pulse at cycle 5, 2 random start pulses.
  task automatic run_txn(input logic [7:0] c, input int u, input logic [3:0] p,
                         input int noise, input bit start_in_done, input string tag);
    int   d;
    logic s;
    model(p, u, d, s);
    code     = c;
    progress = p;
    unlock   = 1'b0;
    start    = 1'b1;
    tick();
    start = 1'b0;
    code  = 8'($urandom);
    for (int n = 1; n <= d; n++) begin
      chk($sformatf("%s.keys@%0d", tag, n), keys, exp_keys(c, n));
      chk($sformatf("%s.busy@%0d", tag, n), {3'b0, busy}, 4'b0001);
      chk($sformatf("%s.done@%0d", tag, n), {3'b0, done}, {3'b0, (n == d)});
      chk($sformatf("%s.success@%0d", tag, n), {3'b0, success},
          {3'b0, (n == d) ? s : 1'b0});
      unlock = (n >= u);
      start  = 1'b0;
      if (noise == 1 && n == 5) start = 1'b1;
      if (noise == 2 && $urandom_range(0, 3) == 0) start = 1'b1;
      if (n == d) start = start_in_done;
      code = 8'($urandom);
      tick();
    end
    start  = 1'b0;
    unlock = 1'b0;
    chk_idle({tag, ".after"}, s);
    tick();
    chk_idle({tag, ".hold"}, s);
  endtask

  initial begin
    logic [7:0] c;
    int         u;
    logic [3:0] p;

    reset = 1'b1; start = 1'b0; unlock = 1'b0; code = 8'h00; progress = 4'hF;
    tick();
    start = 1'b1; code = 8'hE4;
    tick();
    chk_idle("reset", 1'b0);
    reset = 1'b0; start = 1'b0;
    tick();
    chk_idle("post_reset", 1'b0);

    // Correct code, lock unlocks immediately.
    run_txn(8'b11_10_01_00, 1, 4'hF, 0, 1'b0, "correct");
    // Wrong code, lock never unlocks: timeout.
    run_txn(8'b00_01_10_11, 1000, 4'hF, 0, 1'b0, "timeout");
    // Unlock on the very last wait cycle, and one cycle too late.
    run_txn(8'b01_01_10_10, L + int'(T) - 1, 4'hF, 0, 1'b0, "late_ok");
    run_txn(8'b10_00_11_01, L + int'(T), 4'hF, 0, 1'b0, "too_late");
    // Start while busy and during DONE is ignored.
    run_txn(8'b11_10_01_00, 1, 4'hF, 1, 1'b1, "start_busy");

`ifdef KEY_SEQUENCER_PROGRESS_CHECK_EN
    run_txn(8'b11_10_01_00, 1, 4'b0000, 0, 1'b0, "prog_miss");
    run_txn(8'b11_10_01_00, 1, 4'b0111, 0, 1'b0, "prog_last");
`endif

    // Reset during the second PRESS.
    code = 8'b11_10_01_00; start = 1'b1; unlock = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 1; n < 4; n++) tick();
    chk("midreset.keys_before", keys, 4'b0010);
    reset = 1'b1;
    tick();
    chk_idle("midreset", 1'b0);
    reset = 1'b0; unlock = 1'b0;
    tick();
    chk_idle("midreset.idle", 1'b0);
    run_txn(8'b11_10_01_00, 3, 4'hF, 0, 1'b0, "replay");

    // Random codes, unlock times, progress and start noise.
    for (int i = 0; i < 30; i++) begin
      c = 8'($urandom);
      u = $urandom_range(1, L + int'(T) + 2);
      p = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      run_txn(c, u, p, 2, 1'($urandom), $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
